uart_rx_frame_ctrl: RTL and testbench
=====================================

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of received-byte entries; power of two, 2..16.
REQ-002 baud_clk  in  1  single clock (16x oversampling clock); all state on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 data_parll  in  11  frame from SIPO: [10] start, [9:2] D0..D7 (D0 first received), [1] parity, [0] stop.
REQ-005 recieved_flag  in  1  SIPO frame-complete level; rising edge marks a new frame.
REQ-006 active_flag  in  1  SIPO reception in progress.
REQ-007 parity_en, parity_odd  in  1 each  parity check enable; 1 = odd, 0 = even.
REQ-008 rx_ready  in  1  consumer pop request.
REQ-009 err_clr  in  1  one-cycle pulse clearing all sticky errors.
REQ-010 rx_data  out  8  head-of-FIFO byte (D7..D0); rx_valid  out  1  FIFO non-empty.
REQ-011 fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-012 parity_err, frame_err, overrun_err  out  1 each  sticky error flags.
REQ-013 rx_busy  out  1  active_flag OR FSM not IDLE.

Function
REQ-014 Edge detect: flag_q registers recieved_flag; a new frame is flag=1 AND flag_q=0.
REQ-015 FSM states IDLE, CHECK, WRITE; IDLE->CHECK on new frame, latching data_parll into frame_q the same edge.
REQ-016 CHECK: frame_err_q = (frame_q[10]!=0) OR (frame_q[0]!=1); par_err_q = parity_en AND (XOR of frame_q[9:1] != parity_odd); ->WRITE.
REQ-017 WRITE: if frame_err_q, discard byte and set frame_err; else push byte (byte bit i = D_i = frame_q[9-i]), set parity_err if par_err_q; ->IDLE.
REQ-018 rx_valid rises 3 baud_clk cycles after the edge sampling the recieved_flag rise (empty FIFO, no error).
REQ-019 Pop: rx_valid AND rx_ready removes head at that edge; rx_data shows next entry the following cycle.
REQ-020 Push to full FIFO without same-cycle pop: byte dropped, overrun_err set, count unchanged.
REQ-021 Push and pop same cycle (including full): both occur, count unchanged, no overrun.
REQ-022 rx_ready with FIFO empty: ignored, no underflow, count stays 0.
REQ-023 New-frame edge while FSM not IDLE: frame ignored, overrun_err set.
REQ-024 Pointers wrap modulo FIFO_DEPTH; fifo_count saturates neither below 0 nor above FIFO_DEPTH.
REQ-025 err_clr clears all three flags; if a set event coincides with err_clr, set wins.
REQ-026 parity_en/parity_odd are sampled in CHECK; changes mid-frame affect only frames checked afterwards.

Reset
REQ-027 reset_n low: FSM IDLE, FIFO empty, pointers 0, fifo_count 0, rx_valid 0, rx_data 0, all error flags 0, frame_q 0.
REQ-028 flag_q resets to 1 so a recieved_flag held high across reset release is not taken as a new frame.
REQ-029 Reset mid-CHECK/WRITE aborts the frame; no push occurs.

Structure
REQ-030 Package uart_rx_pkg holds FSM state enum, frame bit-index constants (START=10, D0=9, D7=2, PAR=1, STOP=0), default FIFO_DEPTH.
REQ-031 One sub-module uart_rx_fifo (synchronous, registered head output, count) instantiated once; FSM and checks stay in top.

Verification
REQ-032 Even parity, frame 0x295 (byte 0xA5) -> rx_valid 3 cycles after flag edge, rx_data=0xA5, no errors.
REQ-033 parity_odd=1, same frame 0x295 -> 0xA5 pushed, parity_err=1; err_clr pulse -> parity_err=0.
REQ-034 Frame 0x294 (stop=0) -> nothing pushed, fifo_count 0, frame_err=1.
REQ-035 5 valid frames, rx_ready=0 (DEPTH 4) -> fifo_count=4, overrun_err=1, pops return first four bytes in order.
REQ-036 FIFO full, 5th frame's WRITE coincides with rx_ready=1 -> count stays 4, no overrun, byte order preserved.
REQ-037 reset_n low during CHECK with recieved_flag held high -> after release no push, rx_valid=0, no spurious capture.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame controller.
//   - FSM state encoding for the frame checker
//   - bit positions inside the 11-bit frame delivered by the SIPO
//   - default receive FIFO depth
//   - helper that extracts the data byte from a frame
package uart_rx_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int FRAME_W            = 11;

  // Frame layout: start bit first on the line, D0 right after it.
  localparam int BIT_START = 10;
  localparam int BIT_D0    = 9;
  localparam int BIT_D7    = 2;
  localparam int BIT_PAR   = 1;
  localparam int BIT_STOP  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // D0 sits at the MSB end of the data field, so the byte is bit-reversed.
  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] frame);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i] = frame[BIT_D0-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with a registered head.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push_i/data_i  : write request and byte
//   pop_req_i      : consumer pop request (honoured only while head_valid_o)
//   head_data_o    : registered head byte
//   head_valid_o   : registered non-empty indication
//   count_o        : occupied entries (0..DEPTH)
//   overflow_o     : push refused because FIFO full with no same-cycle pop
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [7:0]                 data_i,
  input  logic                       pop_req_i,
  output logic [7:0]                 head_data_o,
  output logic                       head_valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    head_data_q;
  logic          head_valid_q;
  logic          full, pop, do_push;

  assign full       = (count_q == FULL_CNT);
  assign pop        = pop_req_i & head_valid_q;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = push_i & (~full | pop);
  assign overflow_o = push_i & full & ~pop;
  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  assign rd_next    = rd_ptr_q + AW'(1);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_data_q  <= '0;
      head_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_next;
      // Head register sees pops immediately but pushes one cycle late,
      // which keeps a held pop request from consuming a stale head.
      if (pop) begin
        head_valid_q <= (count_q != CW'(1));
        if (count_q != CW'(1)) head_data_q <= mem_q[rd_next];
      end else begin
        head_valid_q <= (count_q != '0);
        if (count_q != '0) head_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign head_data_o  = head_data_q;
  assign head_valid_o = head_valid_q;
  assign count_o      = count_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: detects completed SIPO frames, checks
// start/stop/parity, and queues good bytes into a small FIFO.
//   baud_clk, reset_n         : 16x clock, asynchronous active-low reset
//   data_parll                : 11-bit frame {start, D0..D7, parity, stop}
//   recieved_flag             : frame-complete level (rising edge = new frame)
//   active_flag               : SIPO reception in progress
//   parity_en, parity_odd     : parity check enable / odd select
//   rx_ready, err_clr         : consumer pop request, sticky error clear
//   rx_data, rx_valid         : head byte and non-empty flag
//   fifo_count                : occupied FIFO entries
//   parity_err, frame_err, overrun_err : sticky error flags
//   rx_busy                   : reception or frame processing in progress
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          baud_clk,
  input  logic                          reset_n,
  input  logic [FRAME_W-1:0]            data_parll,
  input  logic                          recieved_flag,
  input  logic                          active_flag,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          rx_ready,
  input  logic                          err_clr,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic                          rx_busy
);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               flag_q;
  logic               chk_frame_err_q, chk_frame_err_d;
  logic               chk_par_err_q, chk_par_err_d;
  logic               parity_err_q, frame_err_q, overrun_err_q;
  logic               new_frame, collide, push, set_frame, set_parity;
  logic               fifo_overflow;

  assign new_frame = recieved_flag & ~flag_q;
  // A frame completing while the previous one is still being processed is lost.
  assign collide   = new_frame & (state_q != ST_IDLE);

  always_comb begin
    state_d         = state_q;
    frame_d         = frame_q;
    chk_frame_err_d = chk_frame_err_q;
    chk_par_err_d   = chk_par_err_q;
    push            = 1'b0;
    set_frame       = 1'b0;
    set_parity      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (new_frame) begin
          frame_d = data_parll;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        chk_frame_err_d = frame_q[BIT_START] | ~frame_q[BIT_STOP];
        chk_par_err_d   = parity_en & ((^frame_q[BIT_D0:BIT_PAR]) != parity_odd);
        state_d         = ST_WRITE;
      end
      ST_WRITE: begin
        if (chk_frame_err_q) begin
          set_frame = 1'b1;
        end else begin
          push       = 1'b1;
          set_parity = chk_par_err_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      frame_q         <= '0;
      // Reset high so a flag already asserted at reset release is not a new frame.
      flag_q          <= 1'b1;
      chk_frame_err_q <= 1'b0;
      chk_par_err_q   <= 1'b0;
      parity_err_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      overrun_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_q         <= frame_d;
      flag_q          <= recieved_flag;
      chk_frame_err_q <= chk_frame_err_d;
      chk_par_err_q   <= chk_par_err_d;
      // Set events take priority over a coincident clear.
      parity_err_q    <= (parity_err_q  & ~err_clr) | set_parity;
      frame_err_q     <= (frame_err_q   & ~err_clr) | set_frame;
      overrun_err_q   <= (overrun_err_q & ~err_clr) | collide | fifo_overflow;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (baud_clk),
    .rst_n        (reset_n),
    .push_i       (push),
    .data_i       (frame_byte(frame_q)),
    .pop_req_i    (rx_ready),
    .head_data_o  (rx_data),
    .head_valid_o (rx_valid),
    .count_o      (fifo_count),
    .overflow_o   (fifo_overflow)
  );

  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_busy     = active_flag | (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl (FIFO_DEPTH = 4).
// Expected bytes go into a scoreboard queue when a frame is driven and are
// compared against rx_data when the consumer pops.
module tb_uart_rx_frame_ctrl;

  logic        baud_clk;
  logic        reset_n;
  logic [10:0] data_parll;
  logic        recieved_flag, active_flag;
  logic        parity_en, parity_odd;
  logic        rx_ready, err_clr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [2:0]  fifo_count;
  logic        parity_err, frame_err, overrun_err, rx_busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];

  uart_rx_frame_ctrl #(.FIFO_DEPTH(4)) dut (
    .baud_clk      (baud_clk),
    .reset_n       (reset_n),
    .data_parll    (data_parll),
    .recieved_flag (recieved_flag),
    .active_flag   (active_flag),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .rx_ready      (rx_ready),
    .err_clr       (err_clr),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .fifo_count    (fifo_count),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err),
    .rx_busy       (rx_busy)
  );

  initial baud_clk = 1'b0;
  always #5 baud_clk = ~baud_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame builder: start 0, D0 first, parity chosen for the given sense, stop 1.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic odd);
    logic [10:0] f;
    f     = '0;
    for (int i = 0; i < 8; i++) f[9-i] = b[i];
    f[1]  = (^b) ^ odd;
    f[0]  = 1'b1;
    return f;
  endfunction

  // Drive one frame and wait until the controller is back in IDLE.
  task automatic send_frame(input logic [10:0] f);
    @(negedge baud_clk);
    data_parll    = f;
    recieved_flag = 1'b1;
    @(negedge baud_clk);
    recieved_flag = 1'b0;
    repeat (3) @(negedge baud_clk);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp_b;
    bit         seen;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (rx_valid) begin
        seen = 1;
        break;
      end
      @(negedge baud_clk);
    end
    if (!seen) begin
      check({tag, "_valid_timeout"}, 32'(rx_valid), 32'd1);
    end else begin
      exp_b = exp_q.pop_front();
      check(tag, 32'(rx_data), 32'(exp_b));
      rx_ready = 1'b1;
      @(negedge baud_clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge baud_clk);
    err_clr = 1'b1;
    @(negedge baud_clk);
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] bytes_a [5];
    logic [7:0] bytes_b [5];
    int         lat;
    bytes_a = '{8'h11, 8'h22, 8'h3C, 8'hC3, 8'h5A};
    bytes_b = '{8'h01, 8'h80, 8'hFE, 8'h7F, 8'h96};

    reset_n       = 1'b0;
    data_parll    = '0;
    recieved_flag = 1'b0;
    active_flag   = 1'b0;
    parity_en     = 1'b1;
    parity_odd    = 1'b0;
    rx_ready      = 1'b0;
    err_clr       = 1'b0;
    repeat (3) @(negedge baud_clk);

    // Reset state
    check("rst_valid",   32'(rx_valid),    32'd0);
    check("rst_data",    32'(rx_data),     32'd0);
    check("rst_count",   32'(fifo_count),  32'd0);
    check("rst_par",     32'(parity_err),  32'd0);
    check("rst_frm",     32'(frame_err),   32'd0);
    check("rst_ovr",     32'(overrun_err), 32'd0);
    reset_n = 1'b1;
    @(negedge baud_clk);
    check("idle_busy", 32'(rx_busy), 32'd0);
    active_flag = 1'b1;
    #1;
    check("active_busy", 32'(rx_busy), 32'd1);
    active_flag = 1'b0;

    // Even parity, frame 0x295: latency and data
    @(negedge baud_clk);
    data_parll    = 11'h295;
    recieved_flag = 1'b1;
    exp_q.push_back(8'hA5);
    lat = 0;
    @(posedge baud_clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge baud_clk);
      recieved_flag = 1'b0;
      if (rx_valid) break;
      @(posedge baud_clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    pop_check("even_data");
    check("even_par", 32'(parity_err), 32'd0);
    check("even_frm", 32'(frame_err),  32'd0);

    // Odd parity expected, same frame: byte still pushed, parity error flagged
    parity_odd = 1'b1;
    send_frame(11'h295);
    exp_q.push_back(8'hA5);
    check("odd_par", 32'(parity_err), 32'd1);
    pop_check("odd_data");
    pulse_clr();
    check("odd_par_clr", 32'(parity_err), 32'd0);
    parity_odd = 1'b0;

    // Bad stop bit: discarded, frame error
    send_frame(11'h294);
    check("stop_count", 32'(fifo_count), 32'd0);
    check("stop_valid", 32'(rx_valid),   32'd0);
    check("stop_frm",   32'(frame_err),  32'd1);
    pulse_clr();
    check("stop_frm_clr", 32'(frame_err), 32'd0);

    // Frame error set coinciding with err_clr: set wins
    @(negedge baud_clk);
    data_parll    = 11'h294;
    recieved_flag = 1'b1;
    @(negedge baud_clk);
    recieved_flag = 1'b0;
    @(negedge baud_clk);
    err_clr = 1'b1;
    @(negedge baud_clk);
    err_clr = 1'b0;
    check("clr_vs_set", 32'(frame_err), 32'd1);
    pulse_clr();

    // Pop request on empty FIFO
    @(negedge baud_clk);
    rx_ready = 1'b1;
    repeat (3) @(negedge baud_clk);
    rx_ready = 1'b0;
    check("empty_pop_count", 32'(fifo_count), 32'd0);
    check("empty_pop_valid", 32'(rx_valid),   32'd0);

    // Five frames into a depth-4 FIFO with no consumer
    for (int i = 0; i < 5; i++) begin
      send_frame(mk_frame(bytes_a[i], 1'b0));
      if (i < 4) exp_q.push_back(bytes_a[i]);
    end
    check("full_count", 32'(fifo_count),  32'd4);
    check("full_ovr",   32'(overrun_err), 32'd1);
    check("full_par",   32'(parity_err),  32'd0);
    for (int i = 0; i < 4; i++) pop_check("full_order");
    repeat (2) @(negedge baud_clk);
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_valid", 32'(rx_valid),   32'd0);
    pulse_clr();

    // Full FIFO, fifth push coincides with a pop
    for (int i = 0; i < 4; i++) begin
      send_frame(mk_frame(bytes_b[i], 1'b0));
      exp_q.push_back(bytes_b[i]);
    end
    @(negedge baud_clk);
    data_parll    = mk_frame(bytes_b[4], 1'b0);
    recieved_flag = 1'b1;
    @(negedge baud_clk);
    recieved_flag = 1'b0;
    @(negedge baud_clk);
    check("pp_head", 32'(rx_data), 32'(exp_q.pop_front()));
    rx_ready = 1'b1;
    @(negedge baud_clk);
    rx_ready = 1'b0;
    exp_q.push_back(bytes_b[4]);
    check("pp_count", 32'(fifo_count),  32'd4);
    check("pp_ovr",   32'(overrun_err), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("pp_order");

    // New frame edge while FSM is in WRITE: ignored, overrun
    @(negedge baud_clk);
    data_parll    = mk_frame(8'h3A, 1'b0);
    recieved_flag = 1'b1;
    exp_q.push_back(8'h3A);
    @(negedge baud_clk);
    recieved_flag = 1'b0;
    @(negedge baud_clk);
    data_parll    = mk_frame(8'h44, 1'b0);
    recieved_flag = 1'b1;
    @(negedge baud_clk);
    recieved_flag = 1'b0;
    repeat (3) @(negedge baud_clk);
    check("busy_count", 32'(fifo_count),  32'd1);
    check("busy_ovr",   32'(overrun_err), 32'd1);
    pop_check("busy_data");
    pulse_clr();
    check("busy_ovr_clr", 32'(overrun_err), 32'd0);

    // Parity sense changed after CHECK does not affect the frame in flight
    @(negedge baud_clk);
    data_parll    = mk_frame(8'hB7, 1'b0);
    recieved_flag = 1'b1;
    exp_q.push_back(8'hB7);
    @(negedge baud_clk);
    recieved_flag = 1'b0;
    @(negedge baud_clk);
    parity_odd = 1'b1;
    repeat (3) @(negedge baud_clk);
    parity_odd = 1'b0;
    check("late_par", 32'(parity_err), 32'd0);
    pop_check("late_data");

    // Reset during CHECK with the flag held high
    @(negedge baud_clk);
    data_parll    = mk_frame(8'hE1, 1'b0);
    recieved_flag = 1'b1;
    @(negedge baud_clk);
    reset_n = 1'b0;
    @(negedge baud_clk);
    @(negedge baud_clk);
    reset_n = 1'b1;
    repeat (6) @(negedge baud_clk);
    check("rstmid_valid", 32'(rx_valid),   32'd0);
    check("rstmid_count", 32'(fifo_count), 32'd0);
    check("rstmid_busy",  32'(rx_busy),    32'd0);
    check("rstmid_frm",   32'(frame_err),  32'd0);
    recieved_flag = 1'b0;
    repeat (2) @(negedge baud_clk);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
